// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Holds executed stores between the memory stage and the data memory port
// until the reorder buffer commits them. Entries form a circular FIFO:
// allocation happens at the tail, committed stores drain from the head in
// program order, and a ROB flush frees the youngest (still pending) entries.
// Loads whose word overlaps any buffered store are flagged as hazards so the
// memory stage can stall them.
//
// Ports
//   clk_i, rstn_i         clock (rising edge), asynchronous active-low reset
//   alloc_valid_i         memory stage presents a store this cycle
//   alloc_addr_i          byte address of the store
//   alloc_data_i          lane-aligned store data
//   alloc_size_i          00 byte, 01 half, 10 word (11 illegal)
//   alloc_idx_o           entry the next allocation will use (tail pointer)
//   full_o, empty_o       occupancy flags
//   commit_valid_i        ROB commits entry commit_idx_i this cycle
//   commit_idx_i          entry being committed
//   discard_i             mask of entries flushed by the ROB
//   mem_req_valid_o       head entry is committed and requests memory
//   mem_req_addr_o        word-aligned request address
//   mem_req_data_o        request data
//   mem_req_be_o          request byte enables
//   mem_req_ready_i       memory accepts the request
//   ld_addr_i             address of the load in the memory stage
//   ld_hazard_o           a buffered store touches the load's word
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int STORE_BUFFER_SIZE = 4,
    parameter int IDX_W             = $clog2(STORE_BUFFER_SIZE)
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         alloc_valid_i,
    input  logic [31:0]                  alloc_addr_i,
    input  logic [31:0]                  alloc_data_i,
    input  logic [1:0]                   alloc_size_i,
    output logic [IDX_W-1:0]             alloc_idx_o,
    output logic                         full_o,
    output logic                         empty_o,
    input  logic                         commit_valid_i,
    input  logic [IDX_W-1:0]             commit_idx_i,
    input  logic [STORE_BUFFER_SIZE-1:0] discard_i,
    output logic                         mem_req_valid_o,
    output logic [31:0]                  mem_req_addr_o,
    output logic [31:0]                  mem_req_data_o,
    output logic [3:0]                   mem_req_be_o,
    input  logic                         mem_req_ready_i,
    input  logic [31:0]                  ld_addr_i,
    output logic                         ld_hazard_o
);

    typedef enum logic [1:0] {
        ENTRY_FREE      = 2'd0,
        ENTRY_PENDING   = 2'd1,
        ENTRY_COMMITTED = 2'd2
    } entryState_e;

    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE    = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W + 1)'(STORE_BUFFER_SIZE);

    entryState_e      entryState_q [STORE_BUFFER_SIZE];
    entryState_e      entryState_d [STORE_BUFFER_SIZE];
    logic [31:0]      entryAddr_q  [STORE_BUFFER_SIZE];
    logic [31:0]      entryData_q  [STORE_BUFFER_SIZE];
    logic [1:0]       entrySize_q  [STORE_BUFFER_SIZE];

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W:0]   survivors;

    logic             allocFire;
    logic             drainFire;
    logic             discardAny;
    logic [31:0]      headAddr;
    logic             unusedLdOffset;

    // Only the word address of a load matters for the hazard check.
    assign unusedLdOffset = ^ld_addr_i[1:0];

    assign alloc_idx_o = tail_q;
    assign full_o      = (count_q == FULL_COUNT);
    assign empty_o     = (count_q == '0);
    assign discardAny  = |discard_i;

    // Any flush in flight blocks allocation so the recomputed tail is not
    // disturbed by a store that belongs to the squashed path.
    assign allocFire   = alloc_valid_i && !full_o && !discardAny;
    assign drainFire   = mem_req_valid_o && mem_req_ready_i;

    // Next-state computation for entry states and the FIFO pointers.
    // After a flush only committed entries remain, and they are contiguous
    // from the head, so tail and count are rebuilt from their number.
    always_comb begin
        entryState_d = entryState_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        survivors    = '0;

        if (allocFire) begin
            entryState_d[tail_q] = ENTRY_PENDING;
            tail_d               = tail_q + IDX_ONE;
        end

        if (commit_valid_i && entryState_q[commit_idx_i] == ENTRY_PENDING
            && !discard_i[commit_idx_i]) begin
            entryState_d[commit_idx_i] = ENTRY_COMMITTED;
        end

        if (drainFire) begin
            entryState_d[head_q] = ENTRY_FREE;
            head_d               = head_q + IDX_ONE;
        end

        for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
            if (discard_i[i] && entryState_q[i] == ENTRY_PENDING) begin
                entryState_d[i] = ENTRY_FREE;
            end
        end

        if (discardAny) begin
            for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
                if (entryState_d[i] == ENTRY_COMMITTED) begin
                    survivors = survivors + CNT_ONE;
                end
            end
            tail_d  = head_d + survivors[IDX_W-1:0];
            count_d = survivors;
        end else begin
            count_d = count_q + (allocFire ? CNT_ONE : '0) - (drainFire ? CNT_ONE : '0);
        end
    end

    // State registers; store payload is captured only on a real allocation.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
                entryState_q[i] <= ENTRY_FREE;
                entryAddr_q[i]  <= '0;
                entryData_q[i]  <= '0;
                entrySize_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entryState_q <= entryState_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            if (allocFire) begin
                entryAddr_q[tail_q] <= alloc_addr_i;
                entryData_q[tail_q] <= alloc_data_i;
                entrySize_q[tail_q] <= alloc_size_i;
            end
        end
    end

    // Memory request built from the head entry. Fields are zeroed while no
    // request is valid so the port is quiet whenever nothing is draining.
    always_comb begin
        headAddr        = entryAddr_q[head_q];
        mem_req_valid_o = (entryState_q[head_q] == ENTRY_COMMITTED);
        mem_req_addr_o  = '0;
        mem_req_data_o  = '0;
        mem_req_be_o    = '0;
        if (mem_req_valid_o) begin
            mem_req_addr_o = {headAddr[31:2], 2'b00};
            mem_req_data_o = entryData_q[head_q];
            case (entrySize_q[head_q])
                2'b00:   mem_req_be_o = 4'b0001 << headAddr[1:0];
                2'b01:   mem_req_be_o = 4'b0011 << headAddr[1:0];
                2'b10:   mem_req_be_o = 4'b1111;
                default: mem_req_be_o = 4'b0000;
            endcase
        end
    end

    // Word-granular overlap check against every live entry; size is
    // deliberately ignored so partial overlaps are never missed.
    always_comb begin
        ld_hazard_o = 1'b0;
        for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
            if (entryState_q[i] != ENTRY_FREE
                && entryAddr_q[i][31:2] == ld_addr_i[31:2]) begin
                ld_hazard_o = 1'b1;
            end
        end
        if (empty_o) begin
            ld_hazard_o = 1'b0;
        end
    end

    // Protocol checks on the ROB and memory-stage handshakes.
    always @(posedge clk_i) begin
        if (rstn_i) begin
            if (alloc_valid_i) begin
                assert (!full_o)
                    else $warning("store_buffer: allocation while full dropped");
            end
            if (commit_valid_i) begin
                assert (entryState_q[commit_idx_i] == ENTRY_PENDING && !discard_i[commit_idx_i])
                    else $error("store_buffer: commit of entry %0d that is not pending", commit_idx_i);
            end
            for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
                if (discard_i[i]) begin
                    assert (entryState_q[i] != ENTRY_COMMITTED)
                        else $error("store_buffer: discard of committed entry %0d", i);
                end
            end
            if (mem_req_valid_o) begin
                assert (entrySize_q[head_q] != 2'b11)
                    else $error("store_buffer: illegal store size at head");
                assert (!(entrySize_q[head_q] == 2'b01 && headAddr[0]))
                    else $error("store_buffer: misaligned half store");
                assert (!(entrySize_q[head_q] == 2'b10 && headAddr[1:0] != 2'b00))
                    else $error("store_buffer: misaligned word store");
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//
// Self-checking bench for store_buffer: a table of directed cycles with
// hand-derived expected outputs, hand-written flush / hazard / reset
// sequences, and a randomized phase checked against a queue-based model of
// the buffer's program-order contents.
// ---------------------------------------------------------------------------
module tb_store_buffer;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          allocValid;
    logic [31:0]   allocAddr;
    logic [31:0]   allocData;
    logic [1:0]    allocSize;
    logic [IW-1:0] allocIdx;
    logic          full;
    logic          empty;
    logic          commitValid;
    logic [IW-1:0] commitIdx;
    logic [N-1:0]  discard;
    logic          memReqValid;
    logic [31:0]   memReqAddr;
    logic [31:0]   memReqData;
    logic [3:0]    memReqBe;
    logic          memReqReady;
    logic [31:0]   ldAddr;
    logic          ldHazard;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    store_buffer #(.STORE_BUFFER_SIZE(N)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .alloc_valid_i  (allocValid),
        .alloc_addr_i   (allocAddr),
        .alloc_data_i   (allocData),
        .alloc_size_i   (allocSize),
        .alloc_idx_o    (allocIdx),
        .full_o         (full),
        .empty_o        (empty),
        .commit_valid_i (commitValid),
        .commit_idx_i   (commitIdx),
        .discard_i      (discard),
        .mem_req_valid_o(memReqValid),
        .mem_req_addr_o (memReqAddr),
        .mem_req_data_o (memReqData),
        .mem_req_be_o   (memReqBe),
        .mem_req_ready_i(memReqReady),
        .ld_addr_i      (ldAddr),
        .ld_hazard_o    (ldHazard)
    );

    typedef struct {
        bit            rst;
        logic          av;
        logic [31:0]   aa;
        logic [31:0]   ad;
        logic [1:0]    as;
        logic          cv;
        logic [IW-1:0] ci;
        logic [N-1:0]  disc;
        logic          rdy;
        logic [31:0]   ld;
        logic [IW-1:0] eIdx;
        logic          eFull;
        logic          eEmpty;
        logic          eValid;
        logic [31:0]   eAddr;
        logic [31:0]   eData;
        logic [3:0]    eBe;
        logic          eHaz;
    } vec_t;

    vec_t vecTable[$];

    typedef struct {
        logic [IW-1:0] idx;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [1:0]    size;
        bit            committed;
    } rec_t;

    rec_t modelQ[$];
    int   modelHead;

    function automatic logic [3:0] beOf(input logic [31:0] a, input logic [1:0] s);
        logic [1:0] off;
        off = a[1:0];
        case (s)
            2'd0:    return 4'(1 << off);
            2'd1:    return 4'(3 << off);
            2'd2:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    task automatic compareField(input string tag, input string field,
                                input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s.%s actual=0x%0h expected=0x%0h", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [IW-1:0] eIdx,
                               input logic eFull, input logic eEmpty, input logic eValid,
                               input logic [31:0] eAddr, input logic [31:0] eData,
                               input logic [3:0] eBe, input logic eHaz);
        compareField(tag, "allocIdx", 32'(allocIdx),    32'(eIdx));
        compareField(tag, "full",     32'(full),        32'(eFull));
        compareField(tag, "empty",    32'(empty),       32'(eEmpty));
        compareField(tag, "reqValid", 32'(memReqValid), 32'(eValid));
        compareField(tag, "reqAddr",  memReqAddr,       eAddr);
        compareField(tag, "reqData",  memReqData,       eData);
        compareField(tag, "reqBe",    32'(memReqBe),    32'(eBe));
        compareField(tag, "ldHazard", 32'(ldHazard),    32'(eHaz));
    endtask

    task automatic applyStimulus(input logic av, input logic [31:0] aa, input logic [31:0] ad,
                                 input logic [1:0] as, input logic cv, input logic [IW-1:0] ci,
                                 input logic [N-1:0] disc, input logic rdy, input logic [31:0] ld);
        @(negedge clk);
        allocValid  = av;
        allocAddr   = aa;
        allocData   = ad;
        allocSize   = as;
        commitValid = cv;
        commitIdx   = ci;
        discard     = disc;
        memReqReady = rdy;
        ldAddr      = ld;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rstn        = 1'b0;
        allocValid  = 1'b0;
        allocAddr   = '0;
        allocData   = '0;
        allocSize   = '0;
        commitValid = 1'b0;
        commitIdx   = '0;
        discard     = '0;
        memReqReady = 1'b0;
        ldAddr      = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        modelQ.delete();
        modelHead = 0;
    endtask

    task automatic addVec(input bit rst, input logic av, input logic [31:0] aa, input logic [31:0] ad,
                          input logic [1:0] as, input logic cv, input logic [IW-1:0] ci,
                          input logic [N-1:0] disc, input logic rdy, input logic [31:0] ld,
                          input logic [IW-1:0] eIdx, input logic eFull, input logic eEmpty,
                          input logic eValid, input logic [31:0] eAddr, input logic [31:0] eData,
                          input logic [3:0] eBe, input logic eHaz);
        vec_t v;
        v = '{rst, av, aa, ad, as, cv, ci, disc, rdy, ld,
              eIdx, eFull, eEmpty, eValid, eAddr, eData, eBe, eHaz};
        vecTable.push_back(v);
    endtask

    // Advance the program-order model by one clock edge using the inputs
    // that were presented during the cycle.
    task automatic modelStep(input logic av, input logic [31:0] aa, input logic [31:0] ad,
                             input logic [1:0] as, input logic cv, input logic [IW-1:0] ci,
                             input logic [N-1:0] disc, input logic rdy);
        int   tailPre;
        bit   drain;
        bit   allocOk;
        rec_t keep[$];
        rec_t r;
        tailPre = (modelHead + modelQ.size()) % N;
        drain   = modelQ.size() > 0 && modelQ[0].committed && rdy;
        allocOk = av && modelQ.size() < N && disc == '0;
        if (cv) begin
            foreach (modelQ[i]) if (modelQ[i].idx == ci) modelQ[i].committed = 1'b1;
        end
        if (drain) begin
            void'(modelQ.pop_front());
            modelHead = (modelHead + 1) % N;
        end
        if (disc != '0) begin
            foreach (modelQ[i]) if (modelQ[i].committed) keep.push_back(modelQ[i]);
            modelQ = keep;
        end else if (allocOk) begin
            r = '{IW'(tailPre), aa, ad, as, 1'b0};
            modelQ.push_back(r);
        end
    endtask

    task automatic checkAgainstModel(input string tag);
        logic [IW-1:0] eIdx;
        logic          eValid;
        logic [31:0]   eAddr;
        logic [31:0]   eData;
        logic [3:0]    eBe;
        logic          eHaz;
        eIdx   = IW'((modelHead + modelQ.size()) % N);
        eValid = modelQ.size() > 0 && modelQ[0].committed;
        eAddr  = '0;
        eData  = '0;
        eBe    = '0;
        if (eValid) begin
            eAddr = {modelQ[0].addr[31:2], 2'b00};
            eData = modelQ[0].data;
            eBe   = beOf(modelQ[0].addr, modelQ[0].size);
        end
        eHaz = 1'b0;
        foreach (modelQ[i]) if (modelQ[i].addr[31:2] == ldAddr[31:2]) eHaz = 1'b1;
        checkOutput(tag, eIdx, modelQ.size() == N, modelQ.size() == 0,
                    eValid, eAddr, eData, eBe, eHaz);
    endtask

    initial begin
        rstn = 1'b1;
        modelHead = 0;

        // Single word store: request appears the cycle after commit, then empties.
        addVec(1, 1, 32'h1000, 32'hDEADBEEF, 2'd2, 0, 2'd0, 4'h0, 1, 32'h0, 2'd0, 0, 1, 0, 32'h0,    32'h0,        4'h0, 0);
        addVec(0, 0, 32'h0,    32'h0,        2'd0, 1, 2'd0, 4'h0, 1, 32'h0, 2'd1, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0);
        addVec(0, 0, 32'h0,    32'h0,        2'd0, 0, 2'd0, 4'h0, 1, 32'h0, 2'd1, 0, 0, 1, 32'h1000, 32'hDEADBEEF, 4'hF, 0);
        addVec(0, 0, 32'h0,    32'h0,        2'd0, 0, 2'd0, 4'h0, 1, 32'h0, 2'd1, 0, 1, 0, 32'h0,    32'h0,        4'h0, 0);
        // Fill with ready low, fifth allocation dropped, then drain in order.
        addVec(1, 1, 32'h2003, 32'h11000000, 2'd0, 0, 2'd0, 4'h0, 0, 32'h0,    2'd0, 0, 1, 0, 32'h0,    32'h0,        4'h0, 0);
        addVec(0, 1, 32'h2002, 32'h22220000, 2'd1, 0, 2'd0, 4'h0, 0, 32'h0,    2'd1, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0);
        addVec(0, 1, 32'h2004, 32'h33333333, 2'd2, 0, 2'd0, 4'h0, 0, 32'h0,    2'd2, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0);
        addVec(0, 1, 32'h2000, 32'h00000044, 2'd0, 0, 2'd0, 4'h0, 0, 32'h0,    2'd3, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0);
        addVec(0, 1, 32'h2008, 32'h00000055, 2'd2, 1, 2'd0, 4'h0, 0, 32'h2004, 2'd0, 1, 0, 0, 32'h0,    32'h0,        4'h0, 1);
        addVec(0, 0, 32'h0,    32'h0,        2'd0, 1, 2'd1, 4'h0, 0, 32'h0,    2'd0, 1, 0, 1, 32'h2000, 32'h11000000, 4'h8, 0);
        addVec(0, 0, 32'h0,    32'h0,        2'd0, 1, 2'd2, 4'h0, 0, 32'h0,    2'd0, 1, 0, 1, 32'h2000, 32'h11000000, 4'h8, 0);
        addVec(0, 0, 32'h0,    32'h0,        2'd0, 1, 2'd3, 4'h0, 0, 32'h0,    2'd0, 1, 0, 1, 32'h2000, 32'h11000000, 4'h8, 0);
        addVec(0, 0, 32'h0,    32'h0,        2'd0, 0, 2'd0, 4'h0, 1, 32'h0,    2'd0, 1, 0, 1, 32'h2000, 32'h11000000, 4'h8, 0);
        addVec(0, 0, 32'h0,    32'h0,        2'd0, 0, 2'd0, 4'h0, 1, 32'h0,    2'd0, 0, 0, 1, 32'h2000, 32'h22220000, 4'hC, 0);
        addVec(0, 0, 32'h0,    32'h0,        2'd0, 0, 2'd0, 4'h0, 1, 32'h0,    2'd0, 0, 0, 1, 32'h2004, 32'h33333333, 4'hF, 0);
        addVec(0, 0, 32'h0,    32'h0,        2'd0, 0, 2'd0, 4'h0, 1, 32'h0,    2'd0, 0, 0, 1, 32'h2000, 32'h00000044, 4'h1, 0);
        addVec(0, 0, 32'h0,    32'h0,        2'd0, 0, 2'd0, 4'h0, 1, 32'h2004, 2'd0, 0, 1, 0, 32'h0,    32'h0,        4'h0, 0);

        // Reset then idle.
        doReset();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("idle", 2'd0, 0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
        end

        for (int k = 0; k < vecTable.size(); k++) begin
            if (vecTable[k].rst) doReset();
            applyStimulus(vecTable[k].av, vecTable[k].aa, vecTable[k].ad, vecTable[k].as,
                          vecTable[k].cv, vecTable[k].ci, vecTable[k].disc, vecTable[k].rdy,
                          vecTable[k].ld);
            checkOutput($sformatf("vec%0d", k), vecTable[k].eIdx, vecTable[k].eFull,
                        vecTable[k].eEmpty, vecTable[k].eValid, vecTable[k].eAddr,
                        vecTable[k].eData, vecTable[k].eBe, vecTable[k].eHaz);
        end

        // Flush of the two youngest pending stores behind a committed head.
        doReset();
        applyStimulus(1, 32'h4000, 32'hA0, 2'd2, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h4004, 32'hA1, 2'd2, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h4008, 32'hA2, 2'd2, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0110, 0, 0);
        checkOutput("flushBefore", 2'd3, 0, 0, 1, 32'h4000, 32'hA0, 4'hF, 0);
        applyStimulus(1, 32'h4010, 32'hAAAA0010, 2'd2, 0, 0, 0, 0, 0);
        checkOutput("flushAfter", 2'd1, 0, 0, 1, 32'h4000, 32'hA0, 4'hF, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h4004);
        checkOutput("flushRealloc", 2'd2, 0, 0, 1, 32'h4000, 32'hA0, 4'hF, 0);
        applyStimulus(0, 0, 0, 0, 1, 2'd1, 0, 0, 32'h4010);
        checkOutput("flushOneDrain", 2'd2, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flushNext", 2'd2, 0, 0, 1, 32'h4010, 32'hAAAA0010, 4'hF, 0);
        rstn = 1'b0;
        #1;
        checkOutput("midDrainReset", 2'd0, 0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Load hazard against a pending byte store.
        doReset();
        applyStimulus(1, 32'h2004, 32'hAB, 2'd0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h2006);
        checkOutput("hazardHit", 2'd1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h2008);
        checkOutput("hazardMiss", 2'd1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0);

        // Wrap-around rounds with toggling ready, then randomized traffic.
        doReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic          av;
            logic [31:0]   aa;
            logic [31:0]   ad;
            logic [1:0]    as;
            logic          cv;
            logic [IW-1:0] ci;
            logic [N-1:0]  disc;
            logic          rdy;
            logic [31:0]   ld;
            int            firstPending;
            firstPending = -1;
            foreach (modelQ[i]) begin
                if (!modelQ[i].committed && firstPending < 0) firstPending = i;
            end
            as = 2'($urandom_range(0, 2));
            case (as)
                2'd0:    aa = 32'h3000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
                2'd1:    aa = 32'h3000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 1) * 2);
                default: aa = 32'h3000 + 32'($urandom_range(0, 15) * 4);
            endcase
            ad   = $urandom;
            ld   = 32'h3000 + 32'($urandom_range(0, 63));
            cv   = 1'b0;
            ci   = '0;
            disc = '0;
            if (cyc < 40) begin
                av  = 1'b1;
                rdy = 1'(cyc % 2);
                cv  = firstPending >= 0;
            end else begin
                av  = 1'($urandom_range(0, 1));
                rdy = 1'($urandom_range(0, 1));
                if (firstPending >= 0 && $urandom_range(0, 15) == 0) begin
                    for (int i = firstPending; i < modelQ.size(); i++) disc[modelQ[i].idx] = 1'b1;
                end else if (firstPending >= 0 && $urandom_range(0, 1) == 1) begin
                    cv = 1'b1;
                end
            end
            if (modelQ.size() >= N) av = 1'b0;
            if (cv) ci = modelQ[firstPending].idx;
            applyStimulus(av, aa, ad, as, cv, ci, disc, rdy, ld);
            checkAgainstModel($sformatf("rand%0d", cyc));
            modelStep(av, aa, ad, as, cv, ci, disc, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
